// File: rtl/alu_pkg.sv
// Shared ALU status-flag definitions: bit positions, flag struct and op-select encoding.
package alu_pkg;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/arith_flag_gen.sv
// Combinational Z/N/C/V derivation for an N-bit add/subtract result.
module arith_flag_gen
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] result,
  input  logic         cout,
  input  logic         select,
  input  logic         a_msb,
  input  logic         b_msb,
  output logic [3:0]   flags
);

  flags_t f;

  always_comb begin
    f.z = (result == '0);
    f.n = result[N-1];
    f.c = cout;
    // Signed overflow: operand signs agree (add) or differ (sub) and the result sign flips.
    if (select == OP_SUB)
      f.v = (a_msb != b_msb) && (result[N-1] != a_msb);
    else
      f.v = (a_msb == b_msb) && (result[N-1] != a_msb);
  end

  assign flags = f;

endmodule

// File: rtl/arith_result_stage.sv
// Registered result stage: flags at push, 2-entry valid/ready FIFO, saturating overflow counter.
module arith_result_stage
  import alu_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_result,
  input  logic          in_cout,
  input  logic          in_select,
  input  logic          in_a_msb,
  input  logic          in_b_msb,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_result,
  output logic [3:0]    out_flags,
  output logic [1:0]    occupancy,
  output logic [CW-1:0] ovf_count,
  input  logic          ovf_clear
);

  logic [N-1:0] mem_result [2];
  flags_t       mem_flags  [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   occ;
  logic [3:0]   new_flags;
  logic         push;
  logic         pop;
  logic         ovf_push;

  arith_flag_gen #(.N(N)) u_flag_gen (
    .result (in_result),
    .cout   (in_cout),
    .select (in_select),
    .a_msb  (in_a_msb),
    .b_msb  (in_b_msb),
    .flags  (new_flags)
  );

  // Handshake outputs depend only on registered occupancy.
  assign in_ready  = (occ != 2'd2);
  assign out_valid = (occ != 2'd0);
  assign occupancy = occ;

  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign ovf_push = push && new_flags[FLAG_V];

  assign out_result = out_valid ? mem_result[rd_ptr] : '0;
  assign out_flags  = out_valid ? mem_flags[rd_ptr]  : 4'b0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mem_result[i] <= '0;
        mem_flags[i]  <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        mem_result[wr_ptr] <= in_result;
        mem_flags[wr_ptr]  <= new_flags;
        wr_ptr             <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Clear wins over increment, but an overflow accepted in the clearing cycle still counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ovf_count <= '0;
    else if (ovf_clear)
      ovf_count <= ovf_push ? CW'(1) : '0;
    else if (ovf_push && (ovf_count != '1))
      ovf_count <= ovf_count + CW'(1);
  end

endmodule

// File: tb/tb_arith_result_stage.sv
// Randomized and directed checks of arith_result_stage against a queue-based reference model.
module tb_arith_result_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_result;
  logic       in_cout;
  logic       in_select;
  logic       in_a_msb;
  logic       in_b_msb;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_result;
  logic [3:0] out_flags;
  logic [1:0] occupancy;
  logic [3:0] ovf_count;
  logic       ovf_clear;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: queue entries are {flags[3:0], result[3:0]}.
  logic [7:0] q[$];
  int         exp_ovf = 0;

  arith_result_stage #(.N(4), .CW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_cout    (in_cout),
    .in_select  (in_select),
    .in_a_msb   (in_a_msb),
    .in_b_msb   (in_b_msb),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .occupancy  (occupancy),
    .ovf_count  (ovf_count),
    .ovf_clear  (ovf_clear)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference arithmetic from signed integer ranges rather than bit tricks.
  function automatic logic [7:0] ref_entry(input logic [3:0] a, input logic [3:0] b, input logic sel);
    int ua, ub, sa, sb, sr, ur;
    logic z, n, c, v;
    ua = int'(a); ub = int'(b);
    sa = (ua >= 8) ? ua - 16 : ua;
    sb = (ub >= 8) ? ub - 16 : ub;
    sr = sel ? sa - sb : sa + sb;
    ur = sel ? (ua - ub + 16) % 16 : (ua + ub) % 16;
    z = (ur == 0);
    n = (ur >= 8);
    c = sel ? (ua >= ub) : (ua + ub > 15);
    v = (sr > 7) || (sr < -8);
    return {z, n, c, v, 4'(ur)};
  endfunction

  task automatic check_state();
    chk("occupancy", 32'(occupancy), 32'(q.size()));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("in_ready",  32'(in_ready),  32'(q.size() != 2));
    chk("out_result", 32'(out_result), (q.size() != 0) ? 32'(q[0][3:0]) : 32'd0);
    chk("out_flags",  32'(out_flags),  (q.size() != 0) ? 32'(q[0][7:4]) : 32'd0);
    chk("ovf_count", 32'(ovf_count), 32'(exp_ovf));
  endtask

  // One cycle: check at negedge, drive inputs, advance the model to the state after the next posedge.
  task automatic step(input logic v, input logic [3:0] a, input logic [3:0] b, input logic sel,
                      input logic ordy, input logic clr, output logic accepted);
    logic [7:0] e;
    logic       popped;
    @(negedge clk);
    check_state();
    e = ref_entry(a, b, sel);
    in_valid  = v;
    in_result = e[3:0];
    in_cout   = e[5];
    in_select = sel;
    in_a_msb  = a[3];
    in_b_msb  = b[3];
    out_ready = ordy;
    ovf_clear = clr;
    accepted = v && (q.size() < 2);
    popped   = ordy && (q.size() > 0);
    if (popped) void'(q.pop_front());
    if (accepted) q.push_back(e);
    if (accepted && e[4])
      exp_ovf = clr ? 1 : ((exp_ovf == 15) ? 15 : exp_ovf + 1);
    else if (clr)
      exp_ovf = 0;
  endtask

  logic       acc;
  logic       hv;
  logic [3:0] ha, hb;
  logic       hs;

  initial begin
    rst = 1'b1;
    in_valid = 0; in_result = 0; in_cout = 0; in_select = 0;
    in_a_msb = 0; in_b_msb = 0; out_ready = 0; ovf_clear = 0;
    repeat (3) @(negedge clk);
    check_state();
    rst = 1'b0;

    // Add overflow 7+1, held at head.
    step(1, 4'd7, 4'd1, 1'b0, 1'b0, 1'b0, acc);
    step(0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, acc);
    // Sub overflow 8-1 with consumer ready.
    step(1, 4'd8, 4'd1, 1'b1, 1'b1, 1'b0, acc);
    step(0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, acc);
    step(0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, acc);

    // Fill with out_ready low; third push is held upstream until space frees.
    step(1, 4'd5, 4'd5, 1'b1, 1'b0, 1'b0, acc);
    step(1, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0, acc);
    step(1, 4'd2, 4'd3, 1'b0, 1'b0, 1'b0, acc);
    chk("third_push_blocked", 32'(acc), 32'd0);
    step(1, 4'd2, 4'd3, 1'b0, 1'b0, 1'b0, acc);
    step(1, 4'd2, 4'd3, 1'b0, 1'b1, 1'b0, acc);
    chk("third_push_blocked_on_pop", 32'(acc), 32'd0);
    step(1, 4'd2, 4'd3, 1'b0, 1'b1, 1'b0, acc);
    chk("third_push_accepted", 32'(acc), 32'd1);

    // Steady push+pop at occupancy 1 across pointer wrap; also drives ovf saturation.
    for (int i = 0; i < 18; i++)
      step(1, 4'd7, 4'd1, 1'b0, 1'b1, 1'b0, acc);
    step(1, 4'd7, 4'd1, 1'b0, 1'b1, 1'b1, acc);
    step(1, 4'd3, 4'd1, 1'b0, 1'b1, 1'b0, acc);
    step(0, 4'd3, 4'd1, 1'b0, 1'b1, 1'b1, acc);
    step(0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, acc);

    // Random traffic; upstream holds a refused transfer.
    hv = 0; ha = 0; hb = 0; hs = 0;
    for (int i = 0; i < 400; i++) begin
      if (!hv) begin
        hv = ($urandom_range(0, 9) < 7);
        ha = 4'($urandom_range(0, 15));
        hb = 4'($urandom_range(0, 15));
        hs = 1'($urandom_range(0, 1));
      end
      step(hv, ha, hb, hs, ($urandom_range(0, 9) < 5), ($urandom_range(0, 19) == 0), acc);
      if (acc) hv = 0;
    end

    // Fill, then assert reset between edges.
    step(1, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0, acc);
    step(1, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0, acc);
    step(1, 4'd6, 4'd3, 1'b0, 1'b0, 1'b0, acc);
    step(1, 4'd6, 4'd3, 1'b0, 1'b0, 1'b0, acc);
    @(negedge clk);
    check_state();
    chk("pre_reset_full", 32'(occupancy), 32'd2);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    q.delete();
    exp_ovf = 0;
    check_state();
    in_valid = 0;
    @(negedge clk);
    check_state();
    rst = 1'b0;
    step(1, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, acc);
    @(negedge clk);
    check_state();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
